// File: rtl/ram_lsu.sv
// RV32I load/store unit driving a single-port, word-wide synchronous data RAM.
// Optional LSU_MISALIGN_TRAP_EN reports misaligned H/W accesses as errors instead of forcing alignment.
module ram_lsu #(
  parameter  int ANCHO = 32,    // only 32 is supported; lane math assumes four bytes per word
  parameter  int LARGO = 1024,
  localparam int AW    = $clog2(LARGO)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [ANCHO-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [ANCHO-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             ram_write_enable,
  output logic [AW-1:0]    ram_addr,
  output logic [ANCHO-1:0] ram_din,
  input  logic [ANCHO-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR, RMW_RD, RMW_DATA, RMW_WR
  } state_t;

  state_t      state, next_state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        bad_req;
  logic        misalign;
  logic        unused_addr;

  // Bytes above the RAM span are dropped, so addresses wrap modulo 4*LARGO.
  assign unused_addr = ^req_addr[31:AW+2];

  function automatic logic illegal_op(input logic [2:0] f3, input logic we);
    case (f3)
      3'b000, 3'b001, 3'b010: illegal_op = 1'b0;
      3'b100, 3'b101:         illegal_op = we;
      default:                illegal_op = 1'b1;
    endcase
  endfunction

  function automatic logic [ANCHO-1:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                   input logic [ANCHO-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0, h};
      default: load_extend = w;
    endcase
  endfunction

  // Only reached for SB/SH; SH uses lane[1] alone so addr[0] is ignored.
  function automatic logic [ANCHO-1:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                                   input logic [ANCHO-1:0] w, input logic [15:0] d);
    store_merge = w;
    if (f3 == 3'b000) store_merge[{lane, 3'b000} +: 8] = d[7:0];
    else              store_merge[{lane[1], 4'b0000} +: 16] = d;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0]) ||
                    (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign bad_req          = illegal_op(req_funct3, req_we) || misalign;
  assign req_ready        = (state == IDLE);
  assign ram_write_enable = (state == WR) || (state == RMW_WR);

  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RESET_N) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid && !bad_req) begin
          if (!req_we)                  next_state = RD_ADDR;
          else if (req_funct3 == 3'b010) next_state = WR;
          else                          next_state = RMW_RD;
        end
      end
      RD_ADDR:  next_state = RD_DATA;
      RD_DATA:  next_state = IDLE;
      WR:       next_state = IDLE;
      RMW_RD:   next_state = RMW_DATA;
      RMW_DATA: next_state = RMW_WR;
      RMW_WR:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      funct3_q  <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (bad_req) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              funct3_q <= req_funct3;
              lane_q   <= req_addr[1:0];
              wdata_q  <= req_wdata[15:0];
              ram_addr <= req_addr[AW+1:2];
              if (req_we) ram_din <= req_wdata;
            end
          end
        end
        RD_DATA: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_extend(funct3_q, lane_q, ram_dout);
        end
        RMW_DATA: ram_din <= store_merge(funct3_q, lane_q, ram_dout, wdata_q);
        WR, RMW_WR: rsp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu with a behavioural read-first synchronous RAM.
// Expectations for misaligned LW follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_ram_lsu;

  localparam int AW = 10;

  logic          CLK, RESET_N;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          ram_write_enable;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din, ram_dout;

  logic [31:0]   mem [0:1023];
  logic          pre_en;
  logic [AW-1:0] pre_idx;
  logic [31:0]   pre_data;
  int            wr_total;

  int n_checks;
  int n_fail;

  ram_lsu #(.ANCHO(32), .LARGO(1024)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_write_enable(ram_write_enable), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (ram_write_enable) begin
      mem[ram_addr] <= ram_din;
      wr_total      <= wr_total + 1;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    pre_en = 1'b1; pre_idx = AW'(idx); pre_data = data;
    @(negedge CLK);
    pre_en = 1'b0;
  endtask

  // Issued on a falling edge; k counts rising edges after the accepting edge E0.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic er, output int we_k, output logic [AW-1:0] we_addr,
                        output logic rdy);
    lat = -1; rd = '0; er = 1'b0; we_k = -1; we_addr = '0; rdy = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(negedge CLK);
    req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ram_write_enable && we_k < 0) begin
        we_k = k; we_addr = ram_addr;
      end
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err; rdy = req_ready;
        break;
      end
      @(negedge CLK);
    end
  endtask

  int            lat, we_k, wr0;
  logic [31:0]   rd;
  logic          er, rdy;
  logic [AW-1:0] wa;

  initial begin
    n_checks = 0; n_fail = 0; wr_total = 0;
    pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_err",   32'(rsp_err), 32'd0);
    check("rst_we",    32'(ram_write_enable), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_addr",  32'(ram_addr), 32'h0);
    check("rst_din",   ram_din, 32'h0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // SW then LW, back-to-back
    wr0 = wr_total;
    do_req(1'b1, 3'b010, 32'h40, 32'hA2345678, lat, rd, er, we_k, wa, rdy);
    check("sw_lat", 32'(lat), 32'd1);
    check("sw_we_k", 32'(we_k), 32'd0);
    check("sw_err", 32'(er), 32'd0);
    check("sw_ready_in_rsp", 32'(rdy), 32'd1);
    check("sw_writes", 32'(wr_total - wr0), 32'd1);
    check("sw_mem16", mem[16], 32'hA2345678);
    do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rd, er, we_k, wa, rdy);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'hA2345678);
    check("lw_err", 32'(er), 32'd0);
    check("lw_no_we", 32'(we_k), 32'hFFFFFFFF);

    // SB read-modify-write and byte loads
    poke(17, 32'h11223344);
    wr0 = wr_total;
    do_req(1'b1, 3'b000, 32'h45, 32'h000000EE, lat, rd, er, we_k, wa, rdy);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_we_k", 32'(we_k), 32'd2);
    check("sb_writes", 32'(wr_total - wr0), 32'd1);
    check("sb_rdata", rd, 32'h0);
    check("sb_mem17", mem[17], 32'h1122EE44);
    do_req(1'b0, 3'b000, 32'h45, 32'h0, lat, rd, er, we_k, wa, rdy);
    check("lb_rdata", rd, 32'hFFFFFFEE);
    do_req(1'b0, 3'b100, 32'h45, 32'h0, lat, rd, er, we_k, wa, rdy);
    check("lbu_rdata", rd, 32'h000000EE);
    do_req(1'b0, 3'b100, 32'h44, 32'h0, lat, rd, er, we_k, wa, rdy);
    check("lbu_lane0", rd, 32'h00000044);

    // SH upper half and half loads
    poke(32, 32'h0);
    do_req(1'b1, 3'b001, 32'h82, 32'h12348001, lat, rd, er, we_k, wa, rdy);
    check("sh_mem32", mem[32], 32'h80010000);
    do_req(1'b0, 3'b001, 32'h82, 32'h0, lat, rd, er, we_k, wa, rdy);
    check("lh_rdata", rd, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h82, 32'h0, lat, rd, er, we_k, wa, rdy);
    check("lhu_rdata", rd, 32'h00008001);
    do_req(1'b0, 3'b001, 32'h80, 32'h0, lat, rd, er, we_k, wa, rdy);
    check("lh_low", rd, 32'h00000000);

    // Address wrap
    do_req(1'b1, 3'b010, 32'h1000, 32'h00001234, lat, rd, er, we_k, wa, rdy);
    check("wrap_we_addr", 32'(wa), 32'h0);
    check("wrap_mem0", mem[0], 32'h00001234);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, er, we_k, wa, rdy);
    check("wrap_lw", rd, 32'h00001234);

    // Misaligned word load
    wr0 = wr_total;
    do_req(1'b0, 3'b010, 32'h42, 32'h0, lat, rd, er, we_k, wa, rdy);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lat", 32'(lat), 32'd0);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", rd, 32'h0);
`else
    check("mis_lat", 32'(lat), 32'd2);
    check("mis_err", 32'(er), 32'd0);
    check("mis_rdata", rd, 32'hA2345678);
`endif

    // Illegal funct3 and unsigned store
    do_req(1'b0, 3'b011, 32'h40, 32'h0, lat, rd, er, we_k, wa, rdy);
    check("ill011_lat", 32'(lat), 32'd0);
    check("ill011_err", 32'(er), 32'd1);
    check("ill011_rdata", rd, 32'h0);
    check("ill011_ready", 32'(rdy), 32'd1);
    do_req(1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, lat, rd, er, we_k, wa, rdy);
    check("illsbu_err", 32'(er), 32'd1);
    repeat (3) @(negedge CLK);
    check("ill_no_writes", 32'(wr_total - wr0), 32'd0);
    check("ill_mem16", mem[16], 32'hA2345678);

    // Reset during RMW_DATA abandons the store
    poke(17, 32'h11223344);
    wr0 = wr_total;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h45; req_wdata = 32'hEE;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("rstmid_we", 32'(ram_write_enable), 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge CLK);
    check("rstmid_writes", 32'(wr_total - wr0), 32'd0);
    check("rstmid_mem17", mem[17], 32'h11223344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
